key_debouncer: RTL and testbench

- Sits between the keypad scan FSM and the digit shifter.
- Takes the scanner's raw key-valid flag and 4-bit key code, rejects contact bounce on press and release, and emits exactly one single-cycle strobe per physical key press, with a stable latched key code.
- Asserts scan_hold back to the scanner so the scanner freezes on the active column while a key is pressed or bouncing.
- Rejects a second key pressed while the first is still held.

---
 rtl/keypad_pkg.sv | 16 +
 rtl/key_debouncer.sv | 90 +++++++++
 tb/tb_key_debouncer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad types: debouncer FSM states and the 4-bit key code used by
// the scanner, debouncer and digit shifter.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } kb_state_t;

    typedef logic [3:0] key_code_t;

    localparam key_code_t KEY_NONE = 4'h0;

endpackage

// File: rtl/key_debouncer.sv
// Debounces the keypad scanner's key-valid/code pair into one strobe per press,
// and holds the scanner on the active column while a key is down or bouncing.
module key_debouncer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 24000
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      key_valid,
    input  key_code_t key_code,
    output logic      key_strobe,
    output key_code_t key_out,
    output logic      key_held,
    output logic      scan_hold
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    kb_state_t        state;
    logic [CNT_W-1:0] cnt;
    key_code_t        cand;

    // Outputs are written alongside the state transition so they track the
    // state that is being entered, not the one being left.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cand       <= KEY_NONE;
            key_out    <= KEY_NONE;
            key_strobe <= 1'b0;
            key_held   <= 1'b0;
            scan_hold  <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        cand      <= key_code;
                        cnt       <= '0;
                        scan_hold <= 1'b1;
                        state     <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (!key_valid || key_code != cand) begin
                        cnt       <= '0;
                        scan_hold <= 1'b0;
                        state     <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        key_out    <= cand;
                        key_strobe <= 1'b1;
                        key_held   <= 1'b1;
                        state      <= HELD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    // A different code while held is a second key: ignored.
                    if (!key_valid) begin
                        cnt   <= '0;
                        state <= RELEASE_WAIT;
                    end
                end
                RELEASE_WAIT: begin
                    if (key_valid) begin
                        state <= HELD;
                    end else if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        key_held  <= 1'b0;
                        scan_hold <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt       <= '0;
                    key_held  <= 1'b0;
                    scan_hold <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer with DEBOUNCE_CYCLES=4: stimulus tasks queue the
// strobes they expect, a negedge monitor pops them as the DUT strobes.
module tb_key_debouncer;
    import keypad_pkg::*;

    localparam int DC = 4;

    logic      clk = 1'b0;
    logic      reset = 1'b0;
    logic      key_valid = 1'b0;
    key_code_t key_code = 4'h0;
    logic      key_strobe;
    key_code_t key_out;
    logic      key_held;
    logic      scan_hold;

    int vectors = 0;
    int miscompares = 0;
    int edge_n = 0;

    typedef struct {
        int        at_edge;
        key_code_t code;
    } exp_t;
    exp_t sb_q[$];

    key_debouncer #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_strobe (key_strobe),
        .key_out    (key_out),
        .key_held   (key_held),
        .scan_hold  (scan_hold)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Scoreboard consumer: every strobe must match the head of the queue,
    // and every queued strobe must appear on its predicted edge.
    always @(negedge clk) begin
        if (key_strobe === 1'b1) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL strobe_unexpected edge=%0d key_out=%h required no strobe", edge_n, key_out);
            end else begin
                if (sb_q[0].at_edge != edge_n || key_out !== sb_q[0].code) begin
                    miscompares++;
                    $display("FAIL strobe edge=%0d code=%h required edge=%0d code=%h",
                             edge_n, key_out, sb_q[0].at_edge, sb_q[0].code);
                end
                void'(sb_q.pop_front());
            end
        end else if (sb_q.size() != 0 && sb_q[0].at_edge <= edge_n) begin
            vectors++;
            miscompares++;
            $display("FAIL strobe_missing edge=%0d required strobe code=%h at edge=%0d",
                     edge_n, sb_q[0].code, sb_q[0].at_edge);
            void'(sb_q.pop_front());
        end
    end

    task automatic tick(input logic v, input key_code_t c);
        key_valid = v;
        key_code  = c;
        @(posedge clk);
        #1;
    endtask

    // First sample lands on the next edge; strobe follows DC edges later.
    task automatic expect_press(input int extra, input key_code_t c);
        exp_t e;
        e.at_edge = edge_n + 1 + DC + extra;
        e.code    = c;
        sb_q.push_back(e);
    endtask

    task automatic release_key();
        for (int i = 0; i < DC; i++) tick(1'b0, 4'h0);
        vectors++;
        if (key_held !== 1'b1) begin
            miscompares++;
            $display("FAIL release_held_early key_held=%b required 1", key_held);
        end
        tick(1'b0, 4'h0);
        vectors++;
        if (key_held !== 1'b0 || scan_hold !== 1'b0) begin
            miscompares++;
            $display("FAIL release_done key_held=%b scan_hold=%b required 0 0", key_held, scan_hold);
        end
        tick(1'b0, 4'h0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(1'b1, 4'h5);
        tick(1'b1, 4'h5);
        vectors++;
        if (key_strobe !== 1'b0 || key_out !== 4'h0 || key_held !== 1'b0 || scan_hold !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state strobe=%b out=%h held=%b hold=%b required 0 0 0 0",
                     key_strobe, key_out, key_held, scan_hold);
        end
        key_valid = 1'b0;
        reset = 1'b1;
        tick(1'b0, 4'h0);
    endtask

    task automatic test_clean_press();
        expect_press(0, 4'h7);
        tick(1'b1, 4'h7);
        vectors++;
        if (scan_hold !== 1'b1 || key_held !== 1'b0) begin
            miscompares++;
            $display("FAIL clean_scan_hold scan_hold=%b key_held=%b required 1 0", scan_hold, key_held);
        end
        for (int i = 1; i < 10; i++) tick(1'b1, 4'h7);
        vectors++;
        if (key_out !== 4'h7 || key_held !== 1'b1 || scan_hold !== 1'b1) begin
            miscompares++;
            $display("FAIL clean_held out=%h held=%b hold=%b required 7 1 1", key_out, key_held, scan_hold);
        end
        release_key();
    endtask

    task automatic test_bouncy_press();
        logic bounce [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) tick(bounce[i], 4'hA);
        expect_press(0, 4'hA);
        for (int i = 0; i < 8; i++) tick(1'b1, 4'hA);
        vectors++;
        if (key_out !== 4'hA) begin
            miscompares++;
            $display("FAIL bouncy_out key_out=%h required a", key_out);
        end
        release_key();
    endtask

    task automatic test_code_change();
        // Edge 3 sees code 5 and aborts; edge 4 restarts the debounce on 5.
        expect_press(3, 4'h5);
        tick(1'b1, 4'h3);
        tick(1'b1, 4'h3);
        for (int i = 0; i < 8; i++) tick(1'b1, 4'h5);
        vectors++;
        if (key_out !== 4'h5) begin
            miscompares++;
            $display("FAIL code_change_out key_out=%h required 5", key_out);
        end
        release_key();
    endtask

    task automatic test_second_key();
        expect_press(0, 4'h2);
        for (int i = 0; i < 6; i++) tick(1'b1, 4'h2);
        for (int i = 0; i < 20; i++) tick(1'b1, 4'h9);
        vectors++;
        if (key_out !== 4'h2 || key_held !== 1'b1) begin
            miscompares++;
            $display("FAIL second_key out=%h held=%b required 2 1", key_out, key_held);
        end
        release_key();
    endtask

    task automatic test_release_bounce();
        expect_press(0, 4'h1);
        for (int i = 0; i < 6; i++) tick(1'b1, 4'h1);
        tick(1'b0, 4'h0);
        tick(1'b0, 4'h0);
        tick(1'b1, 4'h1);
        vectors++;
        if (key_held !== 1'b1 || key_out !== 4'h1) begin
            miscompares++;
            $display("FAIL release_bounce held=%b out=%h required 1 1", key_held, key_out);
        end
        release_key();
        expect_press(0, 4'h4);
        for (int i = 0; i < 6; i++) tick(1'b1, 4'h4);
        vectors++;
        if (key_out !== 4'h4) begin
            miscompares++;
            $display("FAIL repress_out key_out=%h required 4", key_out);
        end
        release_key();
    endtask

    task automatic test_reset_mid_held();
        expect_press(0, 4'h6);
        for (int i = 0; i < 6; i++) tick(1'b1, 4'h6);
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (key_out !== 4'h0 || key_held !== 1'b0 || scan_hold !== 1'b0 || key_strobe !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset out=%h held=%b hold=%b strobe=%b required 0 0 0 0",
                     key_out, key_held, scan_hold, key_strobe);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        expect_press(0, 4'h6);
        for (int i = 0; i < 6; i++) tick(1'b1, 4'h6);
        vectors++;
        if (key_out !== 4'h6 || key_held !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_repress out=%h held=%b required 6 1", key_out, key_held);
        end
        release_key();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout edge=%0d required completion", edge_n);
        $fatal(1, "timeout");
    end

    initial begin
        #3;
        test_reset();
        test_clean_press();
        test_bouncy_press();
        test_code_change();
        test_second_key();
        test_release_bounce();
        test_reset_mid_held();
        for (int i = 0; i < 4; i++) tick(1'b0, 4'h0);
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain pending=%0d required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
